// File: rtl/det_event_logger.sv
// Timestamped event logger for the serial pattern detector's match pulse.
// Stamps each match with a free-running counter, queues stamps in a FIFO, drained via valid/ready.
module det_event_logger #(
   parameter int unsigned TS_W  = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   det_in,
   input  logic                   clr,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [TS_W-1:0]        ev_ts,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       total_cnt,
   output logic                   overflow
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [TS_W-1:0]  ts_q, ts_d;
   logic [TS_W-1:0]  mem_q [DEPTH];
   logic [TS_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic pop, full, push;

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign pop  = (level_q != '0) && ev_ready;
   assign full = (level_q == LVL_FULL);
   assign push = det_in && (!full || pop);

   always_comb begin
      ts_d     = ts_q + TS_W'(1);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (clr) begin
         ts_d     = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = ts_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
         end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
         end
         if (det_in && full && !pop) begin
            ovf_d = 1'b1;
         end
         if (det_in && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q     <= '0;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ts_q     <= ts_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Outputs decode straight from registers; the head reads as zero when empty.
   assign ev_valid  = (level_q != '0);
   assign ev_ts     = ev_valid ? mem_q[rd_ptr_q] : '0;
   assign level     = level_q;
   assign total_cnt = cnt_q;
   assign overflow  = ovf_q;

endmodule
